urv_dbus_fabric: RTL and testbench
==================================

URV_DBUS_FABRIC -- requirements
Module: urv_dbus_fabric

Interface
REQ-001 The block SHALL have these parameters:
- NSLV, 4, number of slave ports (1..8).
- TIMEOUT, 255, maximum wait cycles for a slave ack (1..65535).
- SLV_BASE, {NSLV x 32'h0}, packed per-slave base addresses; slave i occupies bits [32*i+31:32*i].
- SLV_MASK, {NSLV x 32'hFFFF_0000}, packed per-slave compare masks.
- ERR_DATA, 32'h0, load data returned on error or timeout.

REQ-002 The block SHALL have these ports. Reset is rst, asynchronous, active-low; the clock is clk_i.
- clk_i  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- m_addr_i  in  32  CPU byte address.
- m_data_i  in  32  CPU store data.
- m_sel_i  in  4  CPU byte enables.
- m_store_i  in  1  store request.
- m_load_i  in  1  load request.
- m_ready_o  out  1  fabric accepts a request this cycle.
- m_data_o  out  32  load data.
- m_load_done_o  out  1  load complete pulse.
- m_store_done_o  out  1  store complete pulse.
- s_sel_o  out  NSLV  one-hot slave select.
- s_addr_o  out  32  latched address, broadcast to all slaves.
- s_data_o  out  32  latched store data, broadcast to all slaves.
- s_be_o  out  4  latched byte enables.
- s_we_o  out  1  write strobe.
- s_re_o  out  1  read strobe.
- s_data_i  in  32*NSLV  packed slave read data.
- s_ack_i  in  NSLV  per-slave acknowledge.
- err_o  out  1  sticky bus-error flag.
- err_addr_o  out  32  address of the first error.
- err_clr_i  in  1  clears err_o.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY, DONE; m_ready_o SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted in IDLE when m_load_i or m_store_i is sampled high; if both are high, the request SHALL be treated as a store.
REQ-005 Decode: slave i SHALL match when (m_addr_i & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]); the lowest matching index wins.
REQ-006 On acceptance with a match, the block SHALL latch addr, data, be and we into s_addr_o, s_data_o, s_be_o, s_we_o/s_re_o, assert s_sel_o[i], and go to BUSY.
REQ-007 On acceptance with no match, the block SHALL go directly to DONE with m_data_o=ERR_DATA, set err_o, and drive no s_sel_o.
REQ-008 In BUSY, s_ack_i[i] is honoured only for the selected i; other acks SHALL be ignored.
- On ack, the block SHALL capture the s_data_i slice i into m_data_o (loads only), deassert all slave strobes at the next edge, and go to DONE.
REQ-009 In DONE, m_load_done_o or m_store_done_o (matching the request type) SHALL be high for exactly one cycle, then the FSM returns to IDLE.
- Minimum latency: request sampled at edge k, s_sel_o high during cycle k+1, ack in cycle k+1, done during cycle k+2.
REQ-010 m_data_o SHALL hold its value until the next completed load.
REQ-011 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack. When it reaches TIMEOUT, the block SHALL abort: drop strobes, go to DONE with m_data_o=ERR_DATA (for a load), and set err_o.
REQ-012 An ack in the same cycle as the timeout terminal count SHALL win; no error is raised.
REQ-013 err_o SHALL be sticky. err_addr_o SHALL be captured only when err_o is 0 (first-error capture). err_clr_i SHALL clear err_o. A new error in the same cycle as err_clr_i SHALL leave err_o set and capture the new address.
REQ-014 Requests arriving outside IDLE SHALL be ignored; the CPU holds them until m_ready_o is high.

Reset
REQ-015 While rst=0, all of the following SHALL be 0 and state SHALL be IDLE, taking effect immediately (asynchronous), including mid-transaction: s_sel_o, s_we_o, s_re_o, s_addr_o, s_data_o, s_be_o, m_data_o, both done outputs, err_o, err_addr_o, and the wait counter.
REQ-016 m_ready_o SHALL be 1 during reset and at the first edge after rst is released.

Structure
REQ-017 Package urv_dbus_pkg SHALL hold the FSM state typedef, ADDR_W=32, DATA_W=32, BE_W=4, and the width of the wait counter.
REQ-018 The combinational mask-match and priority encoder SHALL be one sub-module, urv_dbus_decode, producing a one-hot match vector and a hit flag.

Verification
REQ-019 Load with NSLV=4, SLV_BASE[1]=32'h1001_0000, m_addr_i=32'h1001_0004, and slave 1 acking the same cycle with 32'hCAFE_F00D: s_sel_o=4'b0010 for one cycle, then m_load_done_o pulses with m_data_o=32'hCAFE_F00D, for a total latency of 2 cycles.
REQ-020 Store to slave 0 at 32'h0000_0010 with m_sel_i=4'b0011 and a 3-cycle-late ack: s_we_o=1 and s_be_o=4'b0011 hold for 4 cycles, then m_store_done_o pulses once; err_o stays 0.
REQ-021 Load from unmapped address 32'h2000_0000: done pulses 1 cycle after acceptance, m_data_o=ERR_DATA, err_o=1, err_addr_o=32'h2000_0000. A second bad access to 32'h3000_0000 leaves err_addr_o unchanged.
REQ-022 TIMEOUT=4 with no ack: the abort occurs after 4 BUSY cycles, then done pulses and err_o=1. A repeat run with the ack at the terminal cycle produces no error.
REQ-023 rst asserted during BUSY: s_sel_o drops at once, no done pulse occurs, and after release m_ready_o=1 and a fresh load completes normally.

Source files
------------

// File: rtl/urv_dbus_pkg.sv
// urv_dbus_pkg: shared widths, FSM state type and latched request payload
// for the uRV data-bus fabric.
package urv_dbus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    // Wait counter holds up to TIMEOUT-1 (TIMEOUT <= 65535)
    localparam int unsigned WCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Request as presented to the slaves
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        logic              we;
        logic              re;
    } req_t;

endpackage

// File: rtl/urv_dbus_fabric_if.sv
// urv_dbus_fabric_if: CPU-side request bus, slave-side broadcast bus and
// error reporting signals of the data-bus fabric.
//   modport slave  : view of the fabric (serves CPU requests, drives slaves)
//   modport master : view of the CPU / slave environment
interface urv_dbus_fabric_if import urv_dbus_pkg::*; #(
    parameter int unsigned NSLV = 4
);
    logic [ADDR_W-1:0]      m_addr_i;
    logic [DATA_W-1:0]      m_data_i;
    logic [BE_W-1:0]        m_sel_i;
    logic                   m_store_i;
    logic                   m_load_i;
    logic                   m_ready_o;
    logic [DATA_W-1:0]      m_data_o;
    logic                   m_load_done_o;
    logic                   m_store_done_o;
    logic [NSLV-1:0]        s_sel_o;
    logic [ADDR_W-1:0]      s_addr_o;
    logic [DATA_W-1:0]      s_data_o;
    logic [BE_W-1:0]        s_be_o;
    logic                   s_we_o;
    logic                   s_re_o;
    logic [DATA_W*NSLV-1:0] s_data_i;
    logic [NSLV-1:0]        s_ack_i;
    logic                   err_o;
    logic [ADDR_W-1:0]      err_addr_o;
    logic                   err_clr_i;

    modport slave (
        input  m_addr_i, m_data_i, m_sel_i, m_store_i, m_load_i,
               s_data_i, s_ack_i, err_clr_i,
        output m_ready_o, m_data_o, m_load_done_o, m_store_done_o,
               s_sel_o, s_addr_o, s_data_o, s_be_o, s_we_o, s_re_o,
               err_o, err_addr_o
    );

    modport master (
        output m_addr_i, m_data_i, m_sel_i, m_store_i, m_load_i,
               s_data_i, s_ack_i, err_clr_i,
        input  m_ready_o, m_data_o, m_load_done_o, m_store_done_o,
               s_sel_o, s_addr_o, s_data_o, s_be_o, s_we_o, s_re_o,
               err_o, err_addr_o
    );

endinterface

// File: rtl/urv_dbus_decode.sv
// urv_dbus_decode: masked address compare against every slave window with
// lowest-index priority.
//   addr_i  : CPU byte address
//   match_c : one-hot winning slave (all zero when nothing matches)
//   hit_c   : at least one slave matched
module urv_dbus_decode import urv_dbus_pkg::*; #(
    parameter int unsigned             NSLV     = 4,
    parameter logic [ADDR_W*NSLV-1:0]  SLV_BASE = {NSLV{32'h0}},
    parameter logic [ADDR_W*NSLV-1:0]  SLV_MASK = {NSLV{32'hFFFF_0000}}
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NSLV-1:0]   match_c,
    output logic              hit_c
);

    // First match in ascending order blocks all later ones
    always_comb begin
        match_c = '0;
        hit_c   = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!hit_c &&
                ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                 (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
                match_c[i] = 1'b1;
                hit_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/urv_dbus_fabric.sv
// urv_dbus_fabric: single-outstanding data-bus fabric between the uRV CPU
// and NSLV memory-mapped slaves, with ack timeout and sticky error capture.
//   clk_i : clock
//   rst   : asynchronous active-low reset
//   bus   : CPU request/response, slave broadcast/ack and error signals
module urv_dbus_fabric import urv_dbus_pkg::*; #(
    parameter int unsigned             NSLV     = 4,
    parameter int unsigned             TIMEOUT  = 255,
    parameter logic [ADDR_W*NSLV-1:0]  SLV_BASE = {NSLV{32'h0}},
    parameter logic [ADDR_W*NSLV-1:0]  SLV_MASK = {NSLV{32'hFFFF_0000}},
    parameter logic [DATA_W-1:0]       ERR_DATA = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst,
    urv_dbus_fabric_if.slave  bus
);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    req_t                req_q, req_d;
    logic [NSLV-1:0]     sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ld_done_q, ld_done_d;
    logic                st_done_q, st_done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [NSLV-1:0]     match_c;
    logic                hit_c;
    logic                ack_sel_c;
    logic [DATA_W-1:0]   ack_data_c;
    logic                new_err_c;
    logic [ADDR_W-1:0]   new_err_addr_c;

    urv_dbus_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr_i  (bus.m_addr_i),
        .match_c (match_c),
        .hit_c   (hit_c)
    );

    // Only the selected slave's ack and data slice are looked at
    always_comb begin
        ack_sel_c  = |(bus.s_ack_i & sel_q);
        ack_data_c = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                ack_data_c = ack_data_c | bus.s_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, request latch, completion and error logic
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        sel_d          = sel_q;
        rdata_d        = rdata_q;
        ld_done_d      = 1'b0;
        st_done_d      = 1'b0;
        wcnt_d         = wcnt_q;
        new_err_c      = 1'b0;
        new_err_addr_c = '0;
        err_d          = err_q;
        err_addr_d     = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.m_load_i || bus.m_store_i) begin
                    if (hit_c) begin
                        req_d.addr = bus.m_addr_i;
                        req_d.data = bus.m_data_i;
                        req_d.be   = bus.m_sel_i;
                        req_d.we   = bus.m_store_i;
                        req_d.re   = !bus.m_store_i;
                        sel_d      = match_c;
                        wcnt_d     = '0;
                        state_d    = ST_BUSY;
                    end else begin
                        new_err_c      = 1'b1;
                        new_err_addr_c = bus.m_addr_i;
                        st_done_d      = bus.m_store_i;
                        ld_done_d      = !bus.m_store_i;
                        if (!bus.m_store_i) begin
                            rdata_d = ERR_DATA;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                // Ack on the terminal count still completes cleanly
                if (ack_sel_c || (wcnt_q == WCNT_W'(TIMEOUT - 1))) begin
                    sel_d     = '0;
                    req_d.we  = 1'b0;
                    req_d.re  = 1'b0;
                    ld_done_d = req_q.re;
                    st_done_d = req_q.we;
                    state_d   = ST_DONE;
                    if (ack_sel_c) begin
                        if (req_q.re) begin
                            rdata_d = ack_data_c;
                        end
                    end else begin
                        new_err_c      = 1'b1;
                        new_err_addr_c = req_q.addr;
                        if (req_q.re) begin
                            rdata_d = ERR_DATA;
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sticky flag; a clear coinciding with a new error re-arms capture
        if (bus.err_clr_i) begin
            err_d = 1'b0;
        end
        if (new_err_c) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr_i) begin
                err_addr_d = new_err_addr_c;
            end
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            req_q      <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            rdata_q    <= rdata_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign bus.m_ready_o      = ready_q;
    assign bus.m_data_o       = rdata_q;
    assign bus.m_load_done_o  = ld_done_q;
    assign bus.m_store_done_o = st_done_q;
    assign bus.s_sel_o        = sel_q;
    assign bus.s_addr_o       = req_q.addr;
    assign bus.s_data_o       = req_q.data;
    assign bus.s_be_o         = req_q.be;
    assign bus.s_we_o         = req_q.we;
    assign bus.s_re_o         = req_q.re;
    assign bus.err_o          = err_q;
    assign bus.err_addr_o     = err_addr_q;

endmodule

// File: tb/tb_urv_dbus_fabric.sv
// tb_urv_dbus_fabric: directed bench for urv_dbus_fabric. Expected
// completions are queued when a request is issued and matched against each
// done pulse; cycle-level strobe behaviour is checked inline.
module tb_urv_dbus_fabric;

    localparam logic [127:0] BASES = {32'h1001_0000, 32'h4000_0000, 32'h1001_0000, 32'h0000_0000};
    localparam logic [127:0] MASKS = {32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [31:0]  EDATA = 32'hBAD0_BAD0;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst   = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ndone = 0;
    exp_t exp_q[$];

    urv_dbus_fabric_if #(.NSLV(4)) bus();

    urv_dbus_fabric #(
        .NSLV     (4),
        .TIMEOUT  (4),
        .SLV_BASE (BASES),
        .SLV_MASK (MASKS),
        .ERR_DATA (EDATA)
    ) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push(input logic is_load, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_load = is_load;
        e.data    = data;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk_i) begin
        if (bus.m_load_done_o === 1'b1 || bus.m_store_done_o === 1'b1) begin
            ndone++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.m_load_done_o), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_load_done", 32'(bus.m_load_done_o), 32'(e.is_load));
                chk("sb_store_done", 32'(bus.m_store_done_o), 32'(!e.is_load));
                if (e.is_load) chk("sb_load_data", bus.m_data_o, e.data);
                chk("sb_err", 32'(bus.err_o), 32'(e.err));
            end
        end
    end

    initial begin
        bus.m_addr_i  = '0;
        bus.m_data_i  = '0;
        bus.m_sel_i   = '0;
        bus.m_store_i = 1'b0;
        bus.m_load_i  = 1'b0;
        bus.s_data_i  = '0;
        bus.s_ack_i   = '0;
        bus.err_clr_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(bus.m_ready_o), 32'h1);
        chk("rst_sel", 32'(bus.s_sel_o), 32'h0);
        chk("rst_err", 32'(bus.err_o), 32'h0);
        chk("rst_mdata", bus.m_data_o, 32'h0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.m_ready_o), 32'h1);

        // Load, same-cycle ack; slave 3 also matches but slave 1 wins
        bus.m_addr_i = 32'h1001_0004;
        bus.m_load_i = 1'b1;
        bus.s_ack_i  = 4'b1010;
        bus.s_data_i = {32'hDEAD_BEEF, 32'h0, 32'hCAFE_F00D, 32'h0};
        push(1'b1, 32'hCAFE_F00D, 1'b0);
        tick();
        chk("ld_sel", 32'(bus.s_sel_o), 32'h2);
        chk("ld_re", 32'(bus.s_re_o), 32'h1);
        chk("ld_we", 32'(bus.s_we_o), 32'h0);
        chk("ld_ready_busy", 32'(bus.m_ready_o), 32'h0);
        chk("ld_saddr", bus.s_addr_o, 32'h1001_0004);
        bus.m_load_i = 1'b0;
        tick();
        chk("ld_done_lat", 32'(bus.m_load_done_o), 32'h1);
        chk("ld_sel_drop", 32'(bus.s_sel_o), 32'h0);
        bus.s_ack_i = '0;
        tick();
        chk("ld_done_once", 32'(bus.m_load_done_o), 32'h0);
        chk("ld_ready_back", 32'(bus.m_ready_o), 32'h1);

        // Store (load also high -> store) to slave 0, ack 3 cycles late
        bus.m_addr_i  = 32'h0000_0010;
        bus.m_data_i  = 32'h1122_3344;
        bus.m_sel_i   = 4'b0011;
        bus.m_store_i = 1'b1;
        bus.m_load_i  = 1'b1;
        push(1'b0, 32'h0, 1'b0);
        tick();
        bus.m_store_i = 1'b0;
        bus.m_load_i  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("st_we_c%0d", c), 32'(bus.s_we_o), 32'h1);
            chk($sformatf("st_be_c%0d", c), 32'(bus.s_be_o), 32'h3);
            chk($sformatf("st_sel_c%0d", c), 32'(bus.s_sel_o), 32'h1);
            chk($sformatf("st_store_done_c%0d", c), 32'(bus.m_store_done_o), 32'h0);
            bus.s_ack_i = (c == 4) ? 4'b0001 : 4'b1110;
            tick();
        end
        bus.s_ack_i = '0;
        chk("st_done", 32'(bus.m_store_done_o), 32'h1);
        chk("st_re", 32'(bus.s_re_o), 32'h0);
        chk("st_sdata", bus.s_data_o, 32'h1122_3344);
        chk("st_we_drop", 32'(bus.s_we_o), 32'h0);
        chk("st_err", 32'(bus.err_o), 32'h0);
        chk("st_mdata_hold", bus.m_data_o, 32'hCAFE_F00D);
        tick();

        // Unmapped load, then a second bad access
        bus.m_addr_i = 32'h2000_0000;
        bus.m_load_i = 1'b1;
        push(1'b1, EDATA, 1'b1);
        tick();
        bus.m_load_i = 1'b0;
        chk("unm_done", 32'(bus.m_load_done_o), 32'h1);
        chk("unm_nosel", 32'(bus.s_sel_o), 32'h0);
        chk("unm_err_addr", bus.err_addr_o, 32'h2000_0000);
        tick();
        bus.m_addr_i  = 32'h3000_0000;
        bus.m_store_i = 1'b1;
        push(1'b0, 32'h0, 1'b1);
        tick();
        bus.m_store_i = 1'b0;
        chk("unm2_err_addr_kept", bus.err_addr_o, 32'h2000_0000);
        tick();

        // Clear coinciding with a new error
        bus.m_addr_i  = 32'h3000_0000;
        bus.m_load_i  = 1'b1;
        bus.err_clr_i = 1'b1;
        push(1'b1, EDATA, 1'b1);
        tick();
        bus.m_load_i  = 1'b0;
        bus.err_clr_i = 1'b0;
        chk("clr_new_err", 32'(bus.err_o), 32'h1);
        chk("clr_new_addr", bus.err_addr_o, 32'h3000_0000);
        tick();
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;
        chk("clr_err", 32'(bus.err_o), 32'h0);

        // Timeout with no ack
        bus.m_addr_i = 32'h4000_0100;
        bus.m_load_i = 1'b1;
        push(1'b1, EDATA, 1'b1);
        tick();
        bus.m_load_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_sel_c%0d", c), 32'(bus.s_sel_o), 32'h4);
            chk($sformatf("to_nodone_c%0d", c), 32'(bus.m_load_done_o), 32'h0);
            tick();
        end
        chk("to_done", 32'(bus.m_load_done_o), 32'h1);
        chk("to_sel_drop", 32'(bus.s_sel_o), 32'h0);
        chk("to_err_addr", bus.err_addr_o, 32'h4000_0100);
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;

        // Repeat with ack on the terminal cycle: no error
        bus.m_load_i = 1'b1;
        bus.s_data_i = {32'h0, 32'h55AA_55AA, 32'h0, 32'h0};
        push(1'b1, 32'h55AA_55AA, 1'b0);
        tick();
        bus.m_load_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            bus.s_ack_i = (c == 4) ? 4'b0100 : 4'b0000;
            tick();
        end
        bus.s_ack_i = '0;
        chk("tt_done", 32'(bus.m_load_done_o), 32'h1);
        chk("tt_err", 32'(bus.err_o), 32'h0);
        tick();

        // Reset during BUSY
        bus.m_addr_i = 32'h0000_0020;
        bus.m_load_i = 1'b1;
        tick();
        bus.m_load_i = 1'b0;
        chk("rb_sel", 32'(bus.s_sel_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("rb_sel_drop", 32'(bus.s_sel_o), 32'h0);
        chk("rb_re", 32'(bus.s_re_o), 32'h0);
        chk("rb_saddr", bus.s_addr_o, 32'h0);
        chk("rb_mdata", bus.m_data_o, 32'h0);
        chk("rb_ready", 32'(bus.m_ready_o), 32'h1);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rb_ready_after", 32'(bus.m_ready_o), 32'h1);
        bus.m_addr_i = 32'h1001_0008;
        bus.m_load_i = 1'b1;
        bus.s_ack_i  = 4'b0010;
        bus.s_data_i = {32'h0, 32'h0, 32'h0BAD_F00D, 32'h0};
        push(1'b1, 32'h0BAD_F00D, 1'b0);
        tick();
        bus.m_load_i = 1'b0;
        tick();
        bus.s_ack_i = '0;
        chk("rb_fresh_done", 32'(bus.m_load_done_o), 32'h1);
        tick(); tick();

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("done_count", 32'(ndone), 32'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
